instr_encoder_loader: RTL and testbench

- Encoder side of the 19-bit ISA: accepts decoded instruction fields (class, func, registers, immediate) over a valid/ready stream, packs them into IR words, and writes them sequentially into instruction memory from a programmed base address.
- Intended uses: program loading from the debug/host link, and generating test programs.
- Each packed word decodes back through the instruction decoder to the same fields.

---
 rtl/instr_encoder_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_instr_encoder_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder_loader.sv
// Purpose : packs decoded 19-bit ISA instruction fields into IR words and writes them
//           sequentially into instruction memory starting at a programmed base address.
// Ports   : clk/rst_n; Start/Base_Addr/Length session control; In_* valid/ready field
//           stream; Imem_* write port (request held until Imem_Ack); Busy/Done status;
//           Err/Err_Code/Err_Count report illegal bundles dropped during the session.
// Latency : bundle accepted at edge N -> Imem_WE from edge N; earliest Ack at N+1.
// Backpr. : In_Ready drops while the word FIFO is full or Length bundles have been taken.
module instr_encoder_loader #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base_Addr,
    input  logic [ADDR_W:0]   Length,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [2:0]        In_Class,
    input  logic [3:0]        In_Func,
    input  logic [3:0]        In_Rd,
    input  logic [3:0]        In_Rs1,
    input  logic [3:0]        In_Rs2,
    input  logic [15:0]       In_Imm,
    output logic              Imem_WE,
    output logic [ADDR_W-1:0] Imem_Addr,
    output logic [18:0]       Imem_Data,
    input  logic              Imem_Ack,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [1:0]        Err_Code,
    output logic [7:0]        Err_Count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_length;
    logic [ADDR_W:0]   r_accepted;
    logic              r_err;
    logic [1:0]        r_err_code;
    logic [7:0]        r_err_cnt;

    logic [18:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic              w_full;
    logic              w_empty;
    logic              w_in_ready;
    logic              w_fire;
    logic              w_push;
    logic              w_pop;
    logic [18:0]       w_word;
    logic              w_bad;
    logic [1:0]        w_bad_code;

    assign w_full     = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    // Ready uses the registered full flag only, so a same-cycle pop never
    // opens a slot for a push.
    assign w_in_ready = (r_state == S_LOAD) && !w_full && (r_accepted < r_length);
    assign w_fire     = In_Valid && w_in_ready;
    assign w_push     = w_fire && !w_bad;
    assign w_pop      = Imem_Ack && !w_empty;

    // Field packer and legality check. Priority when several faults coincide:
    // bad class, then bad func/kind, then immediate overflow.
    always_comb begin
        w_word     = '0;
        w_bad      = 1'b0;
        w_bad_code = 2'b00;
        case (In_Class)
            3'b000: begin
                w_word = {3'b000, In_Rd, In_Rs1, In_Rs2, In_Func};
                if (In_Func > 4'd12) begin
                    w_bad      = 1'b1;
                    w_bad_code = 2'b11;
                end
            end
            3'b001: begin
                if (In_Func[0]) begin
                    w_word = {3'b001, In_Imm[7:4], In_Rs1, In_Imm[3:0], 3'b000, 1'b1};
                end else begin
                    w_word = {3'b001, In_Imm[7:0], In_Rd, 4'b0000};
                end
                if (|In_Imm[15:8]) begin
                    w_bad      = 1'b1;
                    w_bad_code = 2'b10;
                end
            end
            3'b010, 3'b011: begin
                w_word = {In_Class, In_Rs1, In_Rs2, In_Imm[7:0]};
                if (|In_Imm[15:8]) begin
                    w_bad      = 1'b1;
                    w_bad_code = 2'b10;
                end
            end
            3'b100: begin
                // RET carries no target; its target field is forced to zero.
                w_word = {3'b100, (In_Func[1:0] == 2'b10) ? 14'd0 : In_Imm[13:0], In_Func[1:0]};
                if (In_Func[1:0] == 2'b11) begin
                    w_bad      = 1'b1;
                    w_bad_code = 2'b11;
                end else if (|In_Imm[15:14]) begin
                    w_bad      = 1'b1;
                    w_bad_code = 2'b10;
                end
            end
            3'b101: begin
                w_word = {3'b101, In_Rs1, In_Rs2, 8'h00};
            end
            default: begin
                w_bad      = 1'b1;
                w_bad_code = 2'b01;
            end
        endcase
    end

    // Storage array carries no reset; the empty flag masks its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An empty session passes through DRAIN for one cycle so Busy is visible
    // before the Done pulse.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next = (Length == '0) ? S_DRAIN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_accepted == r_length) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_length   <= '0;
            r_accepted <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
            r_err_cnt  <= 8'd0;
        end else if (r_state == S_IDLE) begin
            if (Start) begin
                r_addr     <= Base_Addr;
                r_length   <= Length;
                r_accepted <= '0;
                r_err      <= 1'b0;
                r_err_code <= 2'b00;
                r_err_cnt  <= 8'd0;
            end
        end else begin
            if (w_fire) begin
                r_accepted <= r_accepted + 1'b1;
            end
            if (w_fire && w_bad) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_code <= w_bad_code;
                end
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 1'b1;
                end
            end
            // Address wraps naturally at 2^ADDR_W.
            if (w_pop) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign In_Ready  = w_in_ready;
    assign Imem_WE   = !w_empty;
    assign Imem_Addr = r_addr;
    assign Imem_Data = w_empty ? 19'd0 : r_mem[r_rd_ptr];
    assign Busy      = (r_state == S_LOAD) || (r_state == S_DRAIN);
    assign Done      = (r_state == S_DONE);
    assign Err       = r_err;
    assign Err_Code  = r_err_code;
    assign Err_Count = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Purpose : directed self-checking bench for instr_encoder_loader.
// Ports   : none; drives the DUT with hand-encoded bundles and checks writes/status.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  Base_Addr = '0;
    logic [8:0]  Length = '0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [2:0]  In_Class = '0;
    logic [3:0]  In_Func = '0;
    logic [3:0]  In_Rd = '0;
    logic [3:0]  In_Rs1 = '0;
    logic [3:0]  In_Rs2 = '0;
    logic [15:0] In_Imm = '0;
    logic        Imem_WE;
    logic [7:0]  Imem_Addr;
    logic [18:0] Imem_Data;
    logic        Imem_Ack = 1'b0;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [1:0]  Err_Code;
    logic [7:0]  Err_Count;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [7:0]  wr_addr [$];
    logic [18:0] wr_data [$];

    instr_encoder_loader #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Base_Addr(Base_Addr), .Length(Length),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Class(In_Class), .In_Func(In_Func),
        .In_Rd(In_Rd), .In_Rs1(In_Rs1), .In_Rs2(In_Rs2), .In_Imm(In_Imm),
        .Imem_WE(Imem_WE), .Imem_Addr(Imem_Addr), .Imem_Data(Imem_Data), .Imem_Ack(Imem_Ack),
        .Busy(Busy), .Done(Done), .Err(Err), .Err_Code(Err_Code), .Err_Count(Err_Count)
    );

    always #5 clk = ~clk;

    // Record every write handshake and Done pulse half a cycle before the edge.
    always @(negedge clk) begin
        if (Imem_WE && Imem_Ack) begin
            wr_addr.push_back(Imem_Addr);
            wr_data.push_back(Imem_Data);
        end
        if (Done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
    endtask

    task automatic start(input logic [7:0] base, input logic [8:0] len);
        @(posedge clk); #1;
        Start = 1'b1; Base_Addr = base; Length = len;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic send(input logic [2:0] cls, input logic [3:0] func, input logic [3:0] rd,
                        input logic [3:0] rs1, input logic [3:0] rs2, input logic [15:0] imm);
        int n;
        In_Class = cls; In_Func = func; In_Rd = rd; In_Rs1 = rs1; In_Rs2 = rs2; In_Imm = imm;
        In_Valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!In_Ready && n < 200);
        if (!In_Ready) chk("send_timeout", 1, 0);
        @(posedge clk); #1;
        In_Valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!Done && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, Done}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic chk_write(input string tag, input int idx, input logic [7:0] a, input logic [18:0] d);
        if (idx < wr_data.size()) begin
            chk({tag, "_addr"}, {24'd0, wr_addr[idx]}, {24'd0, a});
            chk({tag, "_data"}, {13'd0, wr_data[idx]}, {13'd0, d});
        end else begin
            chk({tag, "_missing"}, idx, wr_data.size());
        end
    endtask

    logic [18:0] exp_bp [8];
    logic [7:0]  hold_addr;
    logic [18:0] hold_data;

    initial begin
        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we",    {31'd0, Imem_WE}, 0);
        chk("rst_addr",  {24'd0, Imem_Addr}, 0);
        chk("rst_data",  {13'd0, Imem_Data}, 0);
        chk("rst_flags", {27'd0, Busy, Done, Err, In_Ready, 1'b0}, 0);
        chk("rst_errs",  {22'd0, Err_Code, Err_Count}, 0);
        rst_n = 1'b1;

        // ---- basic program, Ack tied high ----
        Imem_Ack = 1'b1;
        clear_log();
        start(8'h10, 9'd5);
        chk("t1_busy", {31'd0, Busy}, 1);
        send(3'b000, 4'd0, 4'd1, 4'd2, 4'd3, 16'h0000);   // ADD
        send(3'b001, 4'd0, 4'd5, 4'd0, 4'd0, 16'h00A7);   // LD
        send(3'b001, 4'd1, 4'd0, 4'd4, 4'd0, 16'h003C);   // ST
        send(3'b011, 4'd0, 4'd0, 4'd1, 4'd2, 16'h0010);   // BNE
        send(3'b100, 4'd1, 4'd0, 4'd0, 4'd0, 16'h0040);   // CALL
        wait_done("t1_done");
        chk("t1_nwr", wr_data.size(), 5);
        chk_write("t1_w0", 0, 8'h10, 19'h01230);
        chk_write("t1_w1", 1, 8'h11, 19'h1A750);
        chk_write("t1_w2", 2, 8'h12, 19'h134C1);
        chk_write("t1_w3", 3, 8'h13, 19'h31210);
        chk_write("t1_w4", 4, 8'h14, 19'h40101);
        repeat (2) @(posedge clk); #1;
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_err", {31'd0, Err}, 0);
        chk("t1_busy_end", {31'd0, Busy}, 0);

        // ---- illegal mix ----
        clear_log();
        start(8'h20, 9'd4);
        send(3'b110, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0000);   // bad class
        send(3'b001, 4'd0, 4'd1, 4'd0, 4'd0, 16'h01FF);   // LD imm overflow
        send(3'b000, 4'd13, 4'd1, 4'd1, 4'd1, 16'h0000);  // R func 13
        send(3'b000, 4'd9, 4'd2, 4'd3, 4'd0, 16'h0000);   // NOT
        wait_done("t2_done");
        chk("t2_nwr", wr_data.size(), 1);
        chk_write("t2_w0", 0, 8'h20, 19'h02309);
        chk("t2_err", {31'd0, Err}, 1);
        chk("t2_code", {30'd0, Err_Code}, 1);
        chk("t2_count", {24'd0, Err_Count}, 3);

        // ---- backpressure: Ack low while streaming 8 bundles ----
        clear_log();
        exp_bp[0] = 19'h00F00; exp_bp[1] = 19'h01E11; exp_bp[2] = 19'h02D22; exp_bp[3] = 19'h03C33;
        exp_bp[4] = 19'h04B44; exp_bp[5] = 19'h05A55; exp_bp[6] = 19'h06966; exp_bp[7] = 19'h07877;
        Imem_Ack = 1'b0;
        start(8'h40, 9'd8);
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(3'b000, 4'(i), 4'(i), 4'(15 - i), 4'(i), 16'h0000);
            end
            begin
                repeat (6) @(posedge clk); #1;
                chk("t3_ready_full", {31'd0, In_Ready}, 0);
                chk("t3_we", {31'd0, Imem_WE}, 1);
                chk("t3_head_addr", {24'd0, Imem_Addr}, 32'h40);
                chk("t3_head_data", {13'd0, Imem_Data}, {13'd0, exp_bp[0]});
                hold_addr = Imem_Addr;
                hold_data = Imem_Data;
                repeat (4) @(posedge clk); #1;
                chk("t3_hold_addr", {24'd0, Imem_Addr}, {24'd0, hold_addr});
                chk("t3_hold_data", {13'd0, Imem_Data}, {13'd0, hold_data});
                chk("t3_ready_still", {31'd0, In_Ready}, 0);
                Imem_Ack = 1'b1;
            end
        join
        wait_done("t3_done");
        chk("t3_nwr", wr_data.size(), 8);
        for (int i = 0; i < 8; i++)
            chk_write("t3_w", i, 8'(8'h40 + i), exp_bp[i]);

        // ---- address wrap ----
        clear_log();
        start(8'hFE, 9'd3);
        send(3'b101, 4'd0, 4'd0, 4'd1, 4'd2, 16'h0000);
        send(3'b101, 4'd0, 4'd0, 4'd3, 4'd4, 16'h0000);
        send(3'b101, 4'd0, 4'd0, 4'd5, 4'd6, 16'h0000);
        wait_done("t4_done");
        chk("t4_nwr", wr_data.size(), 3);
        chk_write("t4_w0", 0, 8'hFE, 19'h51200);
        chk_write("t4_w1", 1, 8'hFF, 19'h53400);
        chk_write("t4_w2", 2, 8'h00, 19'h55600);

        // ---- reset mid-session ----
        clear_log();
        Imem_Ack = 1'b0;
        start(8'h50, 9'd6);
        send(3'b000, 4'd1, 4'd1, 4'd1, 4'd1, 16'h0000);
        send(3'b000, 4'd2, 4'd2, 4'd2, 4'd2, 16'h0000);
        @(posedge clk); #1;
        chk("t5_we_before", {31'd0, Imem_WE}, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_we",   {31'd0, Imem_WE}, 0);
        chk("t5_addr", {24'd0, Imem_Addr}, 0);
        chk("t5_data", {13'd0, Imem_Data}, 0);
        chk("t5_flags", {29'd0, Busy, Done, In_Ready}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("t5_no_done", done_cnt, 0);
        chk("t5_idle_busy", {31'd0, Busy}, 0);
        Imem_Ack = 1'b1;
        start(8'h60, 9'd1);
        send(3'b001, 4'd0, 4'd3, 4'd0, 4'd0, 16'h0012);
        wait_done("t5_done");
        chk("t5_nwr", wr_data.size(), 1);
        chk_write("t5_w0", 0, 8'h60, 19'h11230);

        // ---- zero-length session, Start during Busy ignored ----
        clear_log();
        @(posedge clk); #1;
        Start = 1'b1; Base_Addr = 8'h70; Length = 9'd0;
        @(posedge clk); #1;
        chk("t6_busy", {31'd0, Busy}, 1);
        chk("t6_done_early", {31'd0, Done}, 0);
        Length = 9'd2;                      // Start still high while Busy
        @(posedge clk); #1;
        Start = 1'b0;
        chk("t6_done", {31'd0, Done}, 1);
        chk("t6_busy_done", {31'd0, Busy}, 0);
        @(posedge clk); #1;
        chk("t6_idle", {30'd0, Busy, In_Ready}, 0);
        repeat (3) @(posedge clk); #1;
        chk("t6_no_we", wr_data.size(), 0);
        chk("t6_done_cnt", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
